// File: rtl/region_tx.sv
// Command-output streamer: frames a selected memory region as opcode, word count,
// region data and an XOR checksum, fed byte-wise to an SPI transmitter.
module region_tx #(
  parameter int unsigned WORD_BYTES  = 4,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned LEN_BYTES   = 4,
  parameter int unsigned NUM_REGIONS = 2,
  parameter bit          MSB_FIRST   = 1'b0,
  localparam int unsigned SelW       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_L,
  input  logic                          cmd_send,
  input  logic [SelW-1:0]               region_sel,
  input  logic [7:0]                    opcode,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_begin,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_end,
  input  logic                          abort,
  input  logic                          busy,
  output logic                          write,
  output logic [7:0]                    byte_send,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_r_en,
  input  logic                          mem_done,
  input  logic [WORD_BYTES*8-1:0]       mem_data,
  output logic                          cmd_done,
  output logic                          cmd_err
);

  localparam int unsigned LenW  = LEN_BYTES * 8;
  localparam int unsigned WordW = WORD_BYTES * 8;
  localparam int unsigned ExtW  = (LenW > ADDR_W) ? LenW : ADDR_W;

  typedef enum logic [2:0] {
    StIdle, StHdr, StLen, StLoad, StSend, StCsum, StDone
  } state_e;

  state_e             state_q;
  logic [7:0]         opcode_q;
  logic [ADDR_W-1:0]  cnt_q;
  logic [7:0]         csum_q;
  logic [3:0]         idx_q;
  logic [WordW-1:0]   word_q;
  logic               err_q;

  logic [ADDR_W-1:0]  sel_begin;
  logic [ADDR_W-1:0]  sel_end;
  logic               sel_ok;

  always_comb begin
    sel_begin = '0;
    sel_end   = '0;
    sel_ok    = 1'b0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (region_sel == SelW'(i)) begin
        sel_begin = region_begin[i*ADDR_W +: ADDR_W];
        sel_end   = region_end[i*ADDR_W +: ADDR_W];
        sel_ok    = 1'b1;
      end
    end
  end

  // Count field: zero-extended or truncated copy of the word count.
  logic [ExtW-1:0]  cnt_ext;
  logic [LenW-1:0]  len_field;
  logic [3:0]       len_pos;
  logic [LenW-1:0]  len_shift;
  logic [7:0]       len_byte;

  assign cnt_ext   = ExtW'(cnt_q);
  assign len_field = cnt_ext[LenW-1:0];
  assign len_pos   = MSB_FIRST ? (4'(LEN_BYTES - 1) - idx_q) : idx_q;
  assign len_shift = len_field >> {len_pos, 3'b000};
  assign len_byte  = len_shift[7:0];

  logic [3:0]       data_pos;
  logic [WordW-1:0] data_shift;
  logic [7:0]       data_byte;

  assign data_pos   = MSB_FIRST ? (4'(WORD_BYTES - 1) - idx_q) : idx_q;
  assign data_shift = word_q >> {data_pos, 3'b000};
  assign data_byte  = data_shift[7:0];

  // write still high means the previous byte is being handed over this cycle.
  logic emit_ok;
  assign emit_ok = !busy && !write;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q   <= StIdle;
      opcode_q  <= '0;
      cnt_q     <= '0;
      csum_q    <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      err_q     <= 1'b0;
      write     <= 1'b0;
      byte_send <= '0;
      mem_addr  <= '0;
      mem_r_en  <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      write    <= 1'b0;
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      if (abort && (state_q != StIdle) && (state_q != StDone)) begin
        state_q  <= StDone;
        err_q    <= 1'b1;
        mem_r_en <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cmd_send) begin
              opcode_q <= opcode;
              idx_q    <= '0;
              csum_q   <= '0;
              if (abort || !sel_ok || (sel_end < sel_begin)) begin
                state_q <= StDone;
                err_q   <= 1'b1;
              end else begin
                mem_addr <= sel_begin;
                cnt_q    <= sel_end - sel_begin;
                err_q    <= 1'b0;
                state_q  <= StHdr;
              end
            end
          end
          StHdr: begin
            if (emit_ok) begin
              write     <= 1'b1;
              byte_send <= opcode_q;
              idx_q     <= '0;
              state_q   <= StLen;
            end
          end
          StLen: begin
            if (emit_ok) begin
              write     <= 1'b1;
              byte_send <= len_byte;
              csum_q    <= csum_q ^ len_byte;
              if (idx_q == 4'(LEN_BYTES - 1)) begin
                idx_q <= '0;
                if (cnt_q != '0) begin
                  mem_r_en <= 1'b1;
                  state_q  <= StLoad;
                end else begin
                  state_q <= StCsum;
                end
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end
          end
          StLoad: begin
            if (mem_done) begin
              word_q   <= mem_data;
              mem_r_en <= 1'b0;
              idx_q    <= '0;
              state_q  <= StSend;
            end
          end
          StSend: begin
            if (emit_ok) begin
              write     <= 1'b1;
              byte_send <= data_byte;
              csum_q    <= csum_q ^ data_byte;
              if (idx_q == 4'(WORD_BYTES - 1)) begin
                idx_q    <= '0;
                mem_addr <= mem_addr + ADDR_W'(1);
                cnt_q    <= cnt_q - ADDR_W'(1);
                if (cnt_q != ADDR_W'(1)) begin
                  mem_r_en <= 1'b1;
                  state_q  <= StLoad;
                end else begin
                  state_q <= StCsum;
                end
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end
          end
          StCsum: begin
            // idx_q marks the checksum as issued; leave only once its strobe is out.
            if (idx_q == '0) begin
              if (emit_ok) begin
                write     <= 1'b1;
                byte_send <= csum_q;
                idx_q     <= 4'd1;
              end
            end else begin
              idx_q   <= '0;
              state_q <= StDone;
            end
          end
          StDone: begin
            cmd_done <= 1'b1;
            cmd_err  <= err_q;
            state_q  <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_region_tx.sv
// Bench for region_tx: two instances (LSB-first/4-byte count/2 regions and
// MSB-first/2-byte count/3 regions) driven from one table of command vectors.
module tb_region_tx;

  logic        clk = 1'b0;
  logic        rst_L = 1'b0;
  logic        cmd_send = 1'b0;
  logic [1:0]  sel = '0;
  logic [7:0]  opcode = '0;
  logic [15:0] b0 = '0, e0 = '0, b1 = '0, e1 = '0;
  logic        abort = 1'b0;
  logic        busy = 1'b0;
  int          mem_delay = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        wr0, wr1, mr0, mr1, done0, done1, err_o0, err_o1;
  logic        md0 = 1'b0, md1 = 1'b0;
  logic [7:0]  bs0, bs1;
  logic [15:0] ma0, ma1;
  logic [31:0] mdat0 = '0, mdat1 = '0;

  region_tx #(.WORD_BYTES(4), .ADDR_W(16), .LEN_BYTES(4), .NUM_REGIONS(2), .MSB_FIRST(1'b0)) u_dut0 (
    .clk(clk), .rst_L(rst_L), .cmd_send(cmd_send), .region_sel(sel[0]), .opcode(opcode),
    .region_begin({b1, b0}), .region_end({e1, e0}), .abort(abort), .busy(busy),
    .write(wr0), .byte_send(bs0), .mem_addr(ma0), .mem_r_en(mr0), .mem_done(md0),
    .mem_data(mdat0), .cmd_done(done0), .cmd_err(err_o0)
  );

  region_tx #(.WORD_BYTES(4), .ADDR_W(16), .LEN_BYTES(2), .NUM_REGIONS(3), .MSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst_L(rst_L), .cmd_send(cmd_send), .region_sel(sel), .opcode(opcode),
    .region_begin({16'h0040, b1, b0}), .region_end({16'h0041, e1, e0}), .abort(abort),
    .busy(busy), .write(wr1), .byte_send(bs1), .mem_addr(ma1), .mem_r_en(mr1),
    .mem_done(md1), .mem_data(mdat1), .cmd_done(done1), .cmd_err(err_o1)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0010: mem_word = 32'h44332211;
      16'h0011: mem_word = 32'h88776655;
      16'h0012: mem_word = 32'hCAFEF00D;
      default:  mem_word = {16'h0BAD, a};
    endcase
  endfunction

  // Memory responders: mem_done one cycle after mem_delay idle cycles of request.
  int w0 = 0, w1 = 0;
  always @(posedge clk) begin
    md0 <= 1'b0;
    if (mr0 && !md0) begin
      if (w0 >= mem_delay) begin md0 <= 1'b1; mdat0 <= mem_word(ma0); w0 <= 0; end
      else w0 <= w0 + 1;
    end else w0 <= 0;
  end
  always @(posedge clk) begin
    md1 <= 1'b0;
    if (mr1 && !md1) begin
      if (w1 >= mem_delay) begin md1 <= 1'b1; mdat1 <= mem_word(ma1); w1 <= 0; end
      else w1 <= w1 + 1;
    end else w1 <= 0;
  end

  // Output monitors.
  logic [7:0] q0[$], q1[$];
  int  dn0, dn1, dc0, dc1, fw0, fw1, lw0, lw1, consec, errleak;
  bit  er0, er1, ren0, ren1, pw0, pw1;
  always @(negedge clk) begin
    if (wr0) begin
      if (q0.size() == 0) fw0 = cyc;
      lw0 = cyc; q0.push_back(bs0);
      if (pw0) consec++;
    end
    if (wr1) begin
      if (q1.size() == 0) fw1 = cyc;
      lw1 = cyc; q1.push_back(bs1);
      if (pw1) consec++;
    end
    pw0 = wr0; pw1 = wr1;
    if (mr0) ren0 = 1'b1;
    if (mr1) ren1 = 1'b1;
    if (done0) begin dn0++; er0 = err_o0; dc0 = cyc; end
    if (done1) begin dn1++; er1 = err_o1; dc1 = cyc; end
    if ((err_o0 && !done0) || (err_o1 && !done1)) errleak++;
  end

  int n_cmp = 0, n_fail = 0, send_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]   sel;
    logic [7:0]   op;
    logic [15:0]  b0, e0, b1, e1;
    int           n0;
    logic [127:0] exp0;  // bytes listed from the top down
    bit           err0;
    int           n1;
    logic [127:0] exp1;
    bit           err1;
    bit           no_ren;
  } vec_t;

  vec_t vecs[5];

  task automatic start_cmd(input vec_t v);
    @(negedge clk);
    q0.delete(); q1.delete();
    dn0 = 0; dn1 = 0; ren0 = 0; ren1 = 0; er0 = 0; er1 = 0;
    sel = v.sel; opcode = v.op; b0 = v.b0; e0 = v.e0; b1 = v.b1; e1 = v.e1;
    cmd_send = 1'b1; send_cyc = cyc;
    @(negedge clk);
    cmd_send = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 600; i++) begin
      if (dn0 > 0 && dn1 > 0) break;
      @(negedge clk);
    end
    n_cmp++;
    if (!(dn0 > 0 && dn1 > 0)) begin
      n_fail++;
      $display("FAIL %s timeout: done0=%0d done1=%0d, expected both 1", name, dn0, dn1);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_stream(input string name, input int inst, input int n,
                              input logic [127:0] exp, input bit err);
    logic [7:0] act;
    int sz = (inst == 0) ? q0.size() : q1.size();
    int dn = (inst == 0) ? dn0 : dn1;
    int dc = (inst == 0) ? dc0 : dc1;
    check($sformatf("%s[%0d] count", name, inst), sz, n);
    for (int i = 0; i < n; i++) begin
      act = (i < sz) ? ((inst == 0) ? q0[i] : q1[i]) : 8'hxx;
      check($sformatf("%s[%0d] byte%0d", name, inst, i), {24'h0, act}, {24'h0, exp[127-8*i -: 8]});
    end
    check($sformatf("%s[%0d] done_pulses", name, inst), dn, 1);
    check($sformatf("%s[%0d] err", name, inst), {31'h0, (inst == 0) ? er0 : er1}, {31'h0, err});
    if (err && n == 0)
      check($sformatf("%s[%0d] err_latency", name, inst), dc - send_cyc, 2);
    if (!err && n > 0) begin
      check($sformatf("%s[%0d] first_wr_lat", name, inst),
            ((inst == 0) ? fw0 : fw1) - send_cyc, 2);
      check($sformatf("%s[%0d] done_lat", name, inst), dc - ((inst == 0) ? lw0 : lw1), 2);
    end
  endtask

  task automatic run_vec(input int k);
    start_cmd(vecs[k]);
    wait_done($sformatf("vec%0d", k));
    check_stream($sformatf("vec%0d", k), 0, vecs[k].n0, vecs[k].exp0, vecs[k].err0);
    check_stream($sformatf("vec%0d", k), 1, vecs[k].n1, vecs[k].exp1, vecs[k].err1);
    if (vecs[k].no_ren) begin
      check($sformatf("vec%0d[0] no_r_en", k), {31'h0, ren0}, 0);
      check($sformatf("vec%0d[1] no_r_en", k), {31'h0, ren1}, 0);
    end
  endtask

  initial begin
    // Two-word region; checksum = 02^11^22^33^44^55^66^77^88 = 8A.
    vecs[0] = '{sel: 2'd1, op: 8'hA5, b0: 16'h0030, e0: 16'h0031, b1: 16'h0010, e1: 16'h0012,
                n0: 14, exp0: 128'hA5020000_00112233_44556677_888A0000, err0: 1'b0,
                n1: 12, exp1: 128'hA5000244_33221188_7766558A_00000000, err1: 1'b0,
                no_ren: 1'b0};
    vecs[1] = '{sel: 2'd0, op: 8'h3C, b0: 16'h0020, e0: 16'h0020, b1: 16'h0010, e1: 16'h0012,
                n0: 6, exp0: 128'h3C000000_00000000_00000000_00000000, err0: 1'b0,
                n1: 4, exp1: 128'h3C000000_00000000_00000000_00000000, err1: 1'b0,
                no_ren: 1'b1};
    vecs[2] = '{sel: 2'd1, op: 8'h5A, b0: 16'h0020, e0: 16'h0020, b1: 16'h0012, e1: 16'h0010,
                n0: 0, exp0: '0, err0: 1'b1, n1: 0, exp1: '0, err1: 1'b1, no_ren: 1'b1};
    // sel=3: out of range for the 3-region instance; the 1-bit select sees region 1.
    vecs[3] = '{sel: 2'd3, op: 8'hC3, b0: 16'h0030, e0: 16'h0031, b1: 16'h0020, e1: 16'h0020,
                n0: 6, exp0: 128'hC3000000_00000000_00000000_00000000, err0: 1'b0,
                n1: 0, exp1: '0, err1: 1'b1, no_ren: 1'b1};
    // One word at 0x11; checksum = 01^55^66^77^88 = CD.
    vecs[4] = '{sel: 2'd0, op: 8'h7E, b0: 16'h0011, e0: 16'h0012, b1: 16'h0010, e1: 16'h0012,
                n0: 10, exp0: 128'h7E010000_00556677_88CD0000_00000000, err0: 1'b0,
                n1: 8, exp1: 128'h7E000188_776655CD_00000000_00000000, err1: 1'b0,
                no_ren: 1'b0};

    repeat (3) @(negedge clk);
    check("reset write", {31'h0, wr0}, 0);
    check("reset byte_send", {24'h0, bs0}, 0);
    check("reset mem_r_en", {31'h0, mr0}, 0);
    check("reset mem_addr", {16'h0, ma0}, 0);
    check("reset cmd_done", {31'h0, done0}, 0);
    check("reset cmd_err", {31'h0, err_o0}, 0);
    rst_L = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 5; k++) run_vec(k);

    // Busy stall mid-SEND plus slow memory.
    mem_delay = 5;
    start_cmd(vecs[0]);
    for (int i = 0; i < 300 && q0.size() < 6; i++) @(negedge clk);
    busy = 1'b1;
    repeat (10) @(negedge clk);
    busy = 1'b0;
    wait_done("stall");
    check_stream("stall", 0, vecs[0].n0, vecs[0].exp0, 1'b0);
    check_stream("stall", 1, vecs[0].n1, vecs[0].exp1, 1'b0);

    // Abort during the second LOAD.
    mem_delay = 8;
    start_cmd(vecs[0]);
    for (int i = 0; i < 300 && !(q0.size() == 9 && mr0); i++) @(negedge clk);
    check("abort reached 2nd load", {31'h0, mr0}, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort r_en drop", {31'h0, mr0}, 0);
    wait_done("abort");
    check("abort bytes", q0.size(), 9);
    check("abort done_pulses", dn0, 1);
    check("abort err0", {31'h0, er0}, 1);
    check("abort err1", {31'h0, er1}, 1);
    mem_delay = 0;
    run_vec(0);

    // Reset mid-command: straight back to IDLE, no completion.
    start_cmd(vecs[0]);
    for (int i = 0; i < 100 && q0.size() < 3; i++) @(negedge clk);
    rst_L = 1'b0;
    #1;
    check("midrst write", {31'h0, wr0}, 0);
    check("midrst r_en", {31'h0, mr0}, 0);
    check("midrst addr", {16'h0, ma0}, 0);
    @(negedge clk);
    rst_L = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst no_done", dn0, 0);
    check("midrst no_more_bytes", q0.size(), 3);
    run_vec(4);

    check("consecutive writes", consec, 0);
    check("cmd_err without cmd_done", errleak, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
